// File: rtl/regfile_pkg.sv
// Shared constants and types for the ALU register file.
// Optional macro REGFILE_ZERO_REG_EN (consumed by regfile_param) hardwires register 0 to zero.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 16;
    localparam int REGFILE_ADDR_W = 3;

    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_word.sv
// One register-file word plus its busy (pending multicycle result) flag.
// A reservation in the same cycle as a load wins, so busy ends up set.
module regfile_word
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              set_busy,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] q,
    output logic              busy
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (load) begin
                q <= d_in;
            end
            if (set_busy) begin
                busy <= 1'b1;
            end else if (load) begin
                busy <= 1'b0;
            end
        end
    end

endmodule : regfile_word

// File: rtl/regfile_param.sv
// Parametrised 1W/2R register file with registered reads, write-first bypass and busy scoreboard.
// Define REGFILE_ZERO_REG_EN to make register 0 a constant zero that can never be reserved.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              rd_valid,
    output logic              busy_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] q       [DEPTH];
    logic [DATA_W-1:0] data_nx [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_nx;
    logic [DEPTH-1:0]  load;
    logic [DEPTH-1:0]  set;

    // data_nx/busy_nx are the post-edge word state; reading them gives write-first bypass.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
`ifdef REGFILE_ZERO_REG_EN
        localparam bit WRITABLE = (i != 0);
`else
        localparam bit WRITABLE = 1'b1;
`endif
        assign load[i]    = WRITABLE && wr  && (wr_addr  == ADDR_W'(i));
        assign set[i]     = WRITABLE && rsv && (rsv_addr == ADDR_W'(i));
        assign data_nx[i] = load[i] ? d_in : q[i];
        assign busy_nx[i] = set[i] | (busy_q[i] & ~load[i]);

        regfile_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .set_busy (set[i]),
            .d_in     (d_in),
            .q        (q[i]),
            .busy     (busy_q[i])
        );
    end

    assign busy_any = |busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out_a  <= '0;
            d_out_b  <= '0;
            busy_a   <= 1'b0;
            busy_b   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                d_out_a <= data_nx[rd_addr_a];
                d_out_b <= data_nx[rd_addr_b];
                busy_a  <= busy_nx[rd_addr_a];
                busy_b  <= busy_nx[rd_addr_b];
            end
        end
    end

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param against an array-based reference model.
// Honours REGFILE_ZERO_REG_EN the same way as the design build.
module tb_regfile_param;
    import regfile_pkg::*;

    localparam int DW    = REGFILE_DATA_W;
    localparam int AW    = REGFILE_ADDR_W;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] d_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          rsv;
    logic [AW-1:0] rsv_addr;
    logic [DW-1:0] d_out_a;
    logic [DW-1:0] d_out_b;
    logic          busy_a;
    logic          busy_b;
    logic          rd_valid;
    logic          busy_any;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state and expected outputs
    reg_data_t m_mem  [DEPTH];
    bit        m_busy [DEPTH];
    reg_data_t e_a, e_b;
    bit        e_busy_a, e_busy_b, e_valid, e_any;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rsv       (rsv),
        .rsv_addr  (rsv_addr),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .rd_valid  (rd_valid),
        .busy_any  (busy_any)
    );

    function automatic bit zero_reg(input int a);
`ifdef REGFILE_ZERO_REG_EN
        return a == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        e_a = '0; e_b = '0; e_busy_a = 0; e_busy_b = 0; e_valid = 0; e_any = 0;
    endfunction

    // Drive one cycle (called just after a rising edge), advance the model, sample at edge+1.
    task automatic step(input bit w, input int wa, input reg_data_t wd,
                        input bit r, input int ra, input int rb,
                        input bit s, input int sa);
        wr = w; wr_addr = AW'(wa); d_in = wd;
        rd_en = r; rd_addr_a = AW'(ra); rd_addr_b = AW'(rb);
        rsv = s; rsv_addr = AW'(sa);
        @(posedge clk);
        if (w && !zero_reg(wa)) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (s && !zero_reg(sa)) m_busy[sa] = 1'b1;
        e_valid = r;
        if (r) begin
            e_a = m_mem[ra]; e_busy_a = m_busy[ra];
            e_b = m_mem[rb]; e_busy_b = m_busy[rb];
        end
        e_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) e_any |= m_busy[i];
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr = 0; wr_addr = '0; d_in = '0; rd_en = 0; rd_addr_a = '0; rd_addr_b = '0;
        rsv = 0; rsv_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({d_out_a, d_out_b, busy_a, busy_b, rd_valid, busy_any} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%h b=%h ba=%b bb=%b v=%b any=%b, want all 0",
                     d_out_a, d_out_b, busy_a, busy_b, rd_valid, busy_any);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_latency();
        step(1, 3, 16'hBEEF, 0, 0, 0, 0, 0);
        idle();
        step(0, 0, '0, 1, 3, 3, 0, 0);
        n_checks++;
        if (d_out_a !== 16'hBEEF || d_out_b !== 16'hBEEF || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_read: got a=%h b=%h v=%b, want BEEF BEEF 1", d_out_a, d_out_b, rd_valid);
        end
        idle();
        n_checks++;
        if (rd_valid !== 1'b0 || d_out_a !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL latency_hold: got v=%b a=%h, want 0 BEEF", rd_valid, d_out_a);
        end
    endtask

    task automatic test_bypass();
        step(1, 6, 16'hA5A5, 1, 6, 1, 0, 0);
        n_checks++;
        if (d_out_a !== 16'hA5A5 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_a: got a=%h ba=%b, want A5A5 0", d_out_a, busy_a);
        end
        n_checks++;
        if (d_out_b !== e_b) begin
            n_fail++;
            $display("FAIL bypass_b_other: got %h, want %h", d_out_b, e_b);
        end
    endtask

    task automatic test_scoreboard();
        step(0, 0, '0, 0, 0, 0, 1, 2);
        n_checks++;
        if (busy_any !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_busy_any_set: got %b, want 1", busy_any);
        end
        step(0, 0, '0, 1, 2, 2, 0, 0);
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_busy_read: got ba=%b bb=%b, want 1 1", busy_a, busy_b);
        end
        step(1, 2, 16'h0042, 0, 0, 0, 0, 0);
        n_checks++;
        if (busy_any !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_busy_any_clear: got %b, want 0", busy_any);
        end
        step(0, 0, '0, 1, 2, 0, 0, 0);
        n_checks++;
        if (busy_a !== 1'b0 || d_out_a !== 16'h0042) begin
            n_fail++;
            $display("FAIL sb_read_after_write: got ba=%b a=%h, want 0 0042", busy_a, d_out_a);
        end
        // reservation and read of the same register in one cycle reports busy
        step(0, 0, '0, 1, 7, 2, 1, 7);
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_rsv_same_cycle: got ba=%b bb=%b, want 1 0", busy_a, busy_b);
        end
        step(1, 7, 16'h0001, 0, 0, 0, 0, 0);
    endtask

    task automatic test_rsv_wr();
        step(1, 4, 16'h7777, 1, 4, 4, 1, 4);
        n_checks++;
        if (d_out_a !== 16'h7777 || busy_a !== 1'b1 || busy_any !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_wr_same: got a=%h ba=%b any=%b, want 7777 1 1", d_out_a, busy_a, busy_any);
        end
        step(0, 0, '0, 1, 4, 0, 0, 0);
        n_checks++;
        if (d_out_a !== 16'h7777 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_wr_after: got a=%h ba=%b, want 7777 1", d_out_a, busy_a);
        end
        step(1, 4, 16'h7778, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reg0();
        step(1, 0, 16'hFFFF, 0, 0, 0, 1, 0);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        n_checks++;
        if (d_out_a !== e_a || d_out_b !== e_b || busy_a !== e_busy_a ||
            busy_b !== e_busy_b || busy_any !== e_any) begin
            n_fail++;
            $display("FAIL reg0: got a=%h b=%h ba=%b bb=%b any=%b, want %h %h %b %b %b",
                     d_out_a, d_out_b, busy_a, busy_b, busy_any, e_a, e_b, e_busy_a, e_busy_b, e_any);
        end
        step(1, 0, 16'h1111, 1, 0, 3, 0, 0);
        n_checks++;
        if (d_out_a !== e_a || d_out_b !== e_b) begin
            n_fail++;
            $display("FAIL reg0_bypass: got a=%h b=%h, want %h %h", d_out_a, d_out_b, e_a, e_b);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, DEPTH-1), reg_data_t'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, DEPTH-1));
            n_checks++;
            if (d_out_a !== e_a || d_out_b !== e_b || busy_a !== e_busy_a || busy_b !== e_busy_b ||
                rd_valid !== e_valid || busy_any !== e_any) begin
                n_fail++;
                $display("FAIL random[%0d]: got a=%h b=%h ba=%b bb=%b v=%b any=%b, want %h %h %b %b %b %b",
                         n, d_out_a, d_out_b, busy_a, busy_b, rd_valid, busy_any,
                         e_a, e_b, e_busy_a, e_busy_b, e_valid, e_any);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 5, 16'h1234, 0, 0, 0, 1, 6);
        step(0, 0, '0, 1, 5, 5, 0, 0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (d_out_a !== '0 || rd_valid !== 1'b0 || busy_any !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got a=%h v=%b any=%b, want 0 0 0", d_out_a, rd_valid, busy_any);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        step(0, 0, '0, 1, 5, 6, 0, 0);
        n_checks++;
        if (d_out_a !== 16'h0000 || busy_b !== 1'b0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read_r5: got a=%h bb=%b v=%b, want 0000 0 1", d_out_a, busy_b, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bypass();
        test_scoreboard();
        test_rsv_wr();
        test_reg0();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_param
